hex_scroll_ctrl: RTL and testbench

HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

---
 rtl/hex_scroll_ctrl_pkg.sv | 15 +
 rtl/hex_scroll_ctrl_seven_seg.sv | 29 ++
 rtl/hex_scroll_ctrl.sv | 124 ++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling hex message display.
package hex_scroll_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } scroll_state_e;

    localparam int unsigned DISP_DIGITS = 6;

    // Segment pattern for digit 0: {dp, g..a}, active-low, dp off.
    localparam logic [7:0] SEG_ZERO = 8'hC0;

endpackage

// File: rtl/hex_scroll_ctrl_seven_seg.sv
// sevenSeg digit encoder: hex nibble to active-low {dp, g..a} pattern.
module hex_scroll_ctrl_seven_seg (
    input  logic [3:0] digit,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = 8'hFF;
        unique case (digit)
            4'h0: seg_c = 8'hC0;
            4'h1: seg_c = 8'hF9;
            4'h2: seg_c = 8'hA4;
            4'h3: seg_c = 8'hB0;
            4'h4: seg_c = 8'h99;
            4'h5: seg_c = 8'h92;
            4'h6: seg_c = 8'h82;
            4'h7: seg_c = 8'hF8;
            4'h8: seg_c = 8'h80;
            4'h9: seg_c = 8'h90;
            4'hA: seg_c = 8'h88;
            4'hB: seg_c = 8'h83;
            4'hC: seg_c = 8'hC6;
            4'hD: seg_c = 8'hA1;
            4'hE: seg_c = 8'h86;
            4'hF: seg_c = 8'h8E;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a MSG_LEN-digit hex message across a six-digit seven-segment display,
// one position per TICK_DIV clocks while running.
module hex_scroll_ctrl
    import hex_scroll_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MSG_LEN  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] pos,
    output logic       wrap,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] POS_LAST = AW'(MSG_LEN - 1);

    scroll_state_e state_q;
    logic [AW-1:0] pos_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    msg [MSG_LEN];
    logic [3:0]    digit [DISP_DIGITS];
    logic [7:0]    seg_c [DISP_DIGITS];

    assign pos = 4'(pos_q);

    // Window read mux; the AW-bit add wraps the window around the buffer end.
    for (genvar k = 0; k < DISP_DIGITS; k++) begin : g_digit
        assign digit[k] = msg[pos_q + AW'(k)];
        hex_scroll_ctrl_seven_seg u_seg (
            .digit (digit[k]),
            .seg_c (seg_c[k])
        );
    end

    // Control FSM, tick counter, message buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            cnt_q    <= '0;
            wrap     <= 1'b0;
            wr_ready <= 1'b1;
            for (int unsigned i = 0; i < MSG_LEN; i++) msg[i] <= '0;
            hex0 <= SEG_ZERO;
            hex1 <= SEG_ZERO;
            hex2 <= SEG_ZERO;
            hex3 <= SEG_ZERO;
            hex4 <= SEG_ZERO;
            hex5 <= SEG_ZERO;
        end else begin
            wrap <= 1'b0;
            hex5 <= seg_c[0];
            hex4 <= seg_c[1];
            hex3 <= seg_c[2];
            hex2 <= seg_c[3];
            hex1 <= seg_c[4];
            hex0 <= seg_c[5];

            if (wr_en && wr_ready) msg[wr_addr[AW-1:0]] <= wr_data;

            // Request priority is clear > stop > start in every state.
            unique case (state_q)
                IDLE: begin
                    if (clear) begin
                        pos_q <= '0;
                    end else if (!stop && start) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        wr_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state_q  <= IDLE;
                        pos_q    <= '0;
                        cnt_q    <= '0;
                        wr_ready <= 1'b1;
                    end else if (stop) begin
                        state_q  <= HOLD;
                        wr_ready <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        pos_q <= pos_q + AW'(1);
                        wrap  <= (pos_q == POS_LAST);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (clear) begin
                        state_q <= IDLE;
                        pos_q   <= '0;
                        cnt_q   <= '0;
                    end else if (!stop && start) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        wr_ready <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl against a behavioural scroll model.
module tb_hex_scroll_ctrl;

    localparam int TICK = 4;
    localparam int LEN  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       wr_ready;
    logic [3:0] pos;
    logic       wrap;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

    hex_scroll_ctrl #(.TICK_DIV(TICK), .MSG_LEN(LEN)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .stop(stop),
        .clear(clear), .pos(pos), .wrap(wrap),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: mode 0=idle, 1=running, 2=frozen
    int m_mode, m_pos, m_cnt, m_wrap;
    int m_msg [LEN];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from current inputs, then compare all outputs.
    task automatic cyc();
        logic [7:0] exp_hex [6];
        logic [7:0] obs_hex [6];
        for (int k = 0; k < 6; k++)
            exp_hex[k] = reset ? seg_tab[0] : seg_tab[m_msg[(m_pos + k) % LEN]];
        if (reset) begin
            m_mode = 0; m_pos = 0; m_cnt = 0; m_wrap = 0;
            for (int i = 0; i < LEN; i++) m_msg[i] = 0;
        end else begin
            m_wrap = 0;
            if (wr_en && m_mode != 1) m_msg[wr_addr] = int'(wr_data);
            if (clear) begin
                m_mode = 0; m_pos = 0; m_cnt = 0;
            end else if (m_mode == 1) begin
                if (stop) m_mode = 2;
                else if (m_cnt == TICK - 1) begin
                    m_cnt = 0;
                    m_wrap = (m_pos == LEN - 1) ? 1 : 0;
                    m_pos = (m_pos + 1) % LEN;
                end else m_cnt++;
            end else if (!stop && start) begin
                m_mode = 1; m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        obs_hex = '{hex5, hex4, hex3, hex2, hex1, hex0};
        chk("pos", 32'(pos), 32'(m_pos));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("wr_ready", 32'(wr_ready), (m_mode == 1) ? 32'd0 : 32'd1);
        for (int k = 0; k < 6; k++) chk($sformatf("hex%0d", 5 - k), 32'(obs_hex[k]), 32'(exp_hex[k]));
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    initial begin
        m_mode = 0; m_pos = 0; m_cnt = 0; m_wrap = 0;
        for (int i = 0; i < LEN; i++) m_msg[i] = 0;

        // Reset state
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_hex0", 32'(hex0), 32'h0C0);
        chk("rst_ready", 32'(wr_ready), 32'd1);

        // Load msg[i]=i while idle, then let the display catch up
        for (int i = 0; i < LEN; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
            cyc();
        end
        idle_inputs();
        cyc();
        chk("load_hex5", 32'(hex5), 32'h0C0);
        chk("load_hex0", 32'(hex0), 32'h092);

        // Clear while idle keeps pos at 0
        clear = 1'b1; cyc(); idle_inputs();

        // Start: first step exactly TICK cycles after entry
        start = 1'b1; cyc(); idle_inputs();
        repeat (TICK - 1) cyc();
        chk("pos_before_step", 32'(pos), 32'd0);
        cyc();
        chk("first_step", 32'(pos), 32'd1);
        repeat (TICK) cyc();
        chk("second_step", 32'(pos), 32'd2);

        // Run to pos 15, show wrapped window, then wrap to 0
        for (int n = 0; n < 200 && m_pos != 15; n++) cyc();
        cyc();
        chk("pos15_hex5", 32'(hex5), 32'h08E);
        chk("pos15_hex0", 32'(hex0), 32'h099);
        for (int n = 0; n < 20 && m_pos != 0; n++) cyc();
        chk("wrap_pos", 32'(pos), 32'd0);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        cyc();
        chk("wrap_single", 32'(wrap), 32'd0);

        // Write dropped while running, accepted once frozen
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd9; cyc();
        wr_en = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
        wr_en = 1'b1; cyc(); wr_en = 1'b0;
        clear = 1'b1; cyc(); clear = 1'b0;
        cyc();
        chk("hold_write_hex2", 32'(hex2), 32'h090);

        // Stop on the step cycle keeps pos
        start = 1'b1; cyc(); start = 1'b0;
        for (int n = 0; n < 20 && m_cnt != TICK - 1; n++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_on_step", 32'(pos), 32'd0);

        // Freeze at pos 7, then clear+stop+start together
        start = 1'b1; cyc(); start = 1'b0;
        for (int n = 0; n < 200 && m_pos != 7; n++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        cyc();
        chk("hold_pos7", 32'(pos), 32'd7);
        start = 1'b1; stop = 1'b1; clear = 1'b1; cyc(); idle_inputs();
        chk("all_req_pos", 32'(pos), 32'd0);
        chk("all_req_wrap", 32'(wrap), 32'd0);
        chk("all_req_ready", 32'(wr_ready), 32'd1);

        // Reset mid-step in RUN
        start = 1'b1; cyc(); start = 1'b0;
        for (int n = 0; n < 20 && m_cnt != TICK - 1; n++) cyc();
        reset = 1'b1; start = 1'b1; cyc(); reset = 1'b0; start = 1'b0;
        chk("rst_run_hex3", 32'(hex3), 32'h0C0);
        cyc();
        chk("rst_msg_hex2", 32'(hex2), 32'h0C0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(63) == 0);
            clear   = ($urandom_range(31) == 0);
            stop    = ($urandom_range(15) == 0);
            start   = ($urandom_range(7) == 0);
            wr_en   = ($urandom_range(1) == 0);
            wr_addr = 4'($urandom_range(15));
            wr_data = 4'($urandom_range(15));
            cyc();
        end
        reset = 1'b0;
        idle_inputs();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
